// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkg
// Description : Shared definitions for the receive frame buffer. Holds the
//               frame classification codes, the frame-entry field layout,
//               the broadcast-ID test and a ceil(log2) helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_pkg;

   // Outcome of classifying one frame event
   typedef enum logic [1:0] {
      CLS_OK  = 2'd0,
      CLS_CRC = 2'd1,
      CLS_ID  = 2'd2,
      CLS_OVF = 2'd3
   } rx_class_e;

   // Smallest r with 2**r >= value
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // Stored entry layout, MSB first: {dest_id, src_id, payload}
   function automatic int entry_w(input int id_w, input int payload_bytes);
      return 2 * id_w + payload_bytes * 8;
   endfunction

   function automatic int src_lsb(input int payload_bytes);
      return payload_bytes * 8;
   endfunction

   function automatic int dest_lsb(input int id_w, input int payload_bytes);
      return id_w + payload_bytes * 8;
   endfunction

   // Broadcast address is the all-ones ID of the given width
   function automatic logic is_bcast(input logic [31:0] id, input int id_w);
      logic [31:0] mask;
      mask = (32'h1 << id_w) - 32'h1;
      return (id & mask) == mask;
   endfunction

endpackage : rx_pkg
`default_nettype wire

// File: rtl/rx_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_fifo
// Description : Synchronous DEPTH-entry FIFO holding complete frame entries.
//               A push into a full FIFO is accepted when a pop happens in the
//               same cycle; a pop on an empty FIFO is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_fifo
   import rx_pkg::*;
#(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_wdata,
   output logic [WIDTH-1:0]       o_rdata,
   output logic [clog2(DEPTH):0]  o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int               PTR_W   = clog2(DEPTH);
   localparam logic [PTR_W:0]   c_DEPTH = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == c_DEPTH);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rptr];

   // A pop frees the tail slot, so a full FIFO can still take a push that cycle
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2**PTR_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

endmodule : rx_frame_fifo
`default_nettype wire

// File: rtl/rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_buffer
// Description : Receive-side frame buffer. Detects frame-complete events,
//               filters on CRC and destination ID, queues accepted frames in
//               a FIFO and keeps saturating per-outcome statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_buffer
   import rx_pkg::*;
#(
   parameter int ID_W          = 2,
   parameter int PAYLOAD_BYTES = 16,
   parameter int DEPTH         = 4,
   parameter int CNT_W         = 16,
   parameter int BCAST_EN      = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [ID_W-1:0]                   my_id,
   input  logic                              frame_valid,
   input  logic                              crc_error,
   input  logic [ID_W-1:0]                   dest_id,
   input  logic [ID_W-1:0]                   src_id,
   input  logic [PAYLOAD_BYTES*8-1:0]        payload,
   input  logic                              clear_stats,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ID_W-1:0]                   out_dest,
   output logic [ID_W-1:0]                   out_src,
   input  logic [clog2(PAYLOAD_BYTES)-1:0]   byte_sel,
   output logic [7:0]                        out_byte,
   output logic [clog2(DEPTH):0]             count,
   output logic                              full,
   output logic [CNT_W-1:0]                  cnt_ok,
   output logic [CNT_W-1:0]                  cnt_crc,
   output logic [CNT_W-1:0]                  cnt_id,
   output logic [CNT_W-1:0]                  cnt_ovf
);

   localparam int               EW        = entry_w(ID_W, PAYLOAD_BYTES);
   localparam int               DEST_LSB  = dest_lsb(ID_W, PAYLOAD_BYTES);
   localparam int               SRC_LSB   = src_lsb(PAYLOAD_BYTES);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic                       r_fv_d;
   logic                       r_armed;
   logic [CNT_W-1:0]           r_cnt_ok;
   logic [CNT_W-1:0]           r_cnt_crc;
   logic [CNT_W-1:0]           r_cnt_id;
   logic [CNT_W-1:0]           r_cnt_ovf;

   logic                       w_event;
   logic                       w_pop;
   logic                       w_push;
   logic                       w_id_match;
   logic                       w_empty;
   rx_class_e                  w_class;
   logic [EW-1:0]              w_wdata;
   logic [EW-1:0]              w_rdata;
   logic [PAYLOAD_BYTES*8-1:0] w_head_payload;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == c_CNT_MAX) ? v : v + 1'b1;
   endfunction

   // r_armed stays low after reset until frame_valid has been seen low, so a
   // level that was already high across reset release cannot fake a new frame
   assign w_event    = frame_valid & ~r_fv_d & r_armed;
   assign w_pop      = out_valid & out_ready;
   assign w_id_match = (dest_id == my_id) |
                       ((BCAST_EN != 0) & is_bcast(32'(dest_id), ID_W));
   assign w_push     = w_event & (w_class == CLS_OK);
   assign w_wdata    = {dest_id, src_id, payload};

   // Rising-edge detector for the frame-complete level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fv_d  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_fv_d <= frame_valid;
         if (!frame_valid) r_armed <= 1'b1;
      end
   end

   // Classify the current frame: CRC beats ID beats overflow
   always_comb begin
      w_class = CLS_OK;
      if (crc_error)
         w_class = CLS_CRC;
      else if (!w_id_match)
         w_class = CLS_ID;
      else if (full && !w_pop)
         w_class = CLS_OVF;
   end

   // Saturating statistics; a clear wins over a coincident event
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt_ok  <= '0;
         r_cnt_crc <= '0;
         r_cnt_id  <= '0;
         r_cnt_ovf <= '0;
      end else if (clear_stats) begin
         r_cnt_ok  <= '0;
         r_cnt_crc <= '0;
         r_cnt_id  <= '0;
         r_cnt_ovf <= '0;
      end else if (w_event) begin
         case (w_class)
            CLS_OK:  r_cnt_ok  <= sat_inc(r_cnt_ok);
            CLS_CRC: r_cnt_crc <= sat_inc(r_cnt_crc);
            CLS_ID:  r_cnt_id  <= sat_inc(r_cnt_id);
            default: r_cnt_ovf <= sat_inc(r_cnt_ovf);
         endcase
      end
   end

   assign cnt_ok  = r_cnt_ok;
   assign cnt_crc = r_cnt_crc;
   assign cnt_id  = r_cnt_id;
   assign cnt_ovf = r_cnt_ovf;

   rx_frame_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata),
      .o_count (count),
      .o_full  (full),
      .o_empty (w_empty)
   );

   // Head is driven only from stored state, never from the incoming frame
   assign out_valid      = ~w_empty;
   assign w_head_payload = w_rdata[PAYLOAD_BYTES*8-1:0];

   // Head frame view, forced to zero when nothing is stored
   always_comb begin
      out_dest = '0;
      out_src  = '0;
      out_byte = '0;
      if (out_valid) begin
         out_dest = w_rdata[DEST_LSB +: ID_W];
         out_src  = w_rdata[SRC_LSB +: ID_W];
         if (int'(byte_sel) < PAYLOAD_BYTES)
            out_byte = w_head_payload[{byte_sel, 3'b000} +: 8];
      end
   end

endmodule : rx_frame_buffer
`default_nettype wire

// File: tb/tb_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_buffer
// Description : Scoreboard bench for rx_frame_buffer. A reference model
//               (queue of frames plus plain integer statistics) runs on the
//               clock; a monitor compares the DUT head and status against it
//               every cycle. A second instance with 2-bit counters shares the
//               stimulus to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_buffer;

   localparam int ID_W    = 2;
   localparam int PB      = 16;
   localparam int DEPTH   = 4;
   localparam int MAX_MAIN = 65535;
   localparam int MAX_SAT  = 3;
   localparam logic [ID_W-1:0] BCAST = '1;

   typedef struct {
      logic [ID_W-1:0] dest;
      logic [ID_W-1:0] src;
      logic [PB*8-1:0] pay;
   } frame_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [ID_W-1:0] my_id = 2'd2;
   logic            frame_valid = 1'b0;
   logic            crc_error = 1'b0;
   logic [ID_W-1:0] dest_id = '0;
   logic [ID_W-1:0] src_id = '0;
   logic [PB*8-1:0] payload = '0;
   logic            clear_stats = 1'b0;
   logic            out_ready = 1'b0;
   logic [3:0]      byte_sel = '0;

   logic            out_valid, full, s_out_valid, s_full;
   logic [ID_W-1:0] out_dest, out_src, s_out_dest, s_out_src;
   logic [7:0]      out_byte, s_out_byte;
   logic [2:0]      count, s_count;
   logic [15:0]     cnt_ok, cnt_crc, cnt_id, cnt_ovf;
   logic [1:0]      s_cnt_ok, s_cnt_crc, s_cnt_id, s_cnt_ovf;

   int     n_vec = 0;
   int     n_miss = 0;
   frame_t sb_q[$];
   int     m_level = 0;
   int     m_ok = 0, m_crc = 0, m_id = 0, m_ovf = 0;
   int     m_last_fv = -1;

   always #5 clk = ~clk;

   rx_frame_buffer u_dut (
      .clk(clk), .rst(rst), .my_id(my_id), .frame_valid(frame_valid),
      .crc_error(crc_error), .dest_id(dest_id), .src_id(src_id),
      .payload(payload), .clear_stats(clear_stats), .out_valid(out_valid),
      .out_ready(out_ready), .out_dest(out_dest), .out_src(out_src),
      .byte_sel(byte_sel), .out_byte(out_byte), .count(count), .full(full),
      .cnt_ok(cnt_ok), .cnt_crc(cnt_crc), .cnt_id(cnt_id), .cnt_ovf(cnt_ovf)
   );

   rx_frame_buffer #(.CNT_W(2)) u_dut_sat (
      .clk(clk), .rst(rst), .my_id(my_id), .frame_valid(frame_valid),
      .crc_error(crc_error), .dest_id(dest_id), .src_id(src_id),
      .payload(payload), .clear_stats(clear_stats), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_dest(s_out_dest), .out_src(s_out_src),
      .byte_sel(byte_sel), .out_byte(s_out_byte), .count(s_count), .full(s_full),
      .cnt_ok(s_cnt_ok), .cnt_crc(s_cnt_crc), .cnt_id(s_cnt_id), .cnt_ovf(s_cnt_ovf)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [PB*8-1:0] rand_pay();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Reference model: a frame is one rising of frame_valid seen after it was
   // sampled low; accepted frames join the expected queue in arrival order
   initial begin : model
      bit     pop, ev;
      frame_t f;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_level = 0; m_ok = 0; m_crc = 0; m_id = 0; m_ovf = 0;
            m_last_fv = -1;
            sb_q.delete();
         end else begin
            pop = (m_level != 0) && out_ready;
            ev  = frame_valid && (m_last_fv == 0);
            m_last_fv = frame_valid ? 1 : 0;
            if (ev) begin
               if (crc_error) begin
                  m_crc++;
               end else if (dest_id != my_id && dest_id != BCAST) begin
                  m_id++;
               end else if (m_level == DEPTH && !pop) begin
                  m_ovf++;
               end else begin
                  f.dest = dest_id; f.src = src_id; f.pay = payload;
                  sb_q.push_back(f);
                  m_level++;
                  m_ok++;
               end
            end
            if (pop) m_level--;
            if (clear_stats) begin
               m_ok = 0; m_crc = 0; m_id = 0; m_ovf = 0;
            end
         end
      end
   end

   // Monitor: compare status every cycle, head against scoreboard front,
   // and retire the front entry whenever the DUT hands it over
   initial begin : monitor
      frame_t hd;
      logic [7:0] eb;
      forever begin
         @(negedge clk);
         check("count", count, m_level);
         check("full", full, m_level == DEPTH);
         check("out_valid", out_valid, m_level != 0);
         check("s_count", s_count, m_level);
         check("s_full", s_full, m_level == DEPTH);
         check("cnt_ok", cnt_ok, sat(m_ok, MAX_MAIN));
         check("cnt_crc", cnt_crc, sat(m_crc, MAX_MAIN));
         check("cnt_id", cnt_id, sat(m_id, MAX_MAIN));
         check("cnt_ovf", cnt_ovf, sat(m_ovf, MAX_MAIN));
         check("s_cnt_ok", s_cnt_ok, sat(m_ok, MAX_SAT));
         check("s_cnt_crc", s_cnt_crc, sat(m_crc, MAX_SAT));
         check("s_cnt_id", s_cnt_id, sat(m_id, MAX_SAT));
         check("s_cnt_ovf", s_cnt_ovf, sat(m_ovf, MAX_SAT));
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL head: out_valid=1 but no frame expected at %0t", $time);
            end else begin
               hd = sb_q[0];
               eb = hd.pay[{byte_sel, 3'b000} +: 8];
               check("out_dest", out_dest, hd.dest);
               check("out_src", out_src, hd.src);
               check("out_byte", out_byte, eb);
               check("s_out_byte", s_out_byte, eb);
               check("s_out_src", s_out_src, hd.src);
               check("s_out_dest", s_out_dest, hd.dest);
               if (out_ready) void'(sb_q.pop_front());
            end
         end else begin
            check("idle_dest", out_dest, 0);
            check("idle_src", out_src, 0);
            check("idle_byte", out_byte, 0);
            check("s_out_valid", s_out_valid, 0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [ID_W-1:0] d, input logic [ID_W-1:0] s,
                       input logic crc, input logic [PB*8-1:0] p);
      dest_id = d; src_id = s; crc_error = crc; payload = p;
      frame_valid = 1'b1;
      cyc();
      frame_valid = 1'b0;
      crc_error = 1'b0;
      cyc();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (DEPTH + 1) cyc();
      out_ready = 1'b0;
   endtask

   task automatic clr();
      clear_stats = 1'b1;
      cyc();
      clear_stats = 1'b0;
   endtask

   initial begin : stim
      logic [PB*8-1:0] p;
      logic [PB*8-1:0] p_new;

      // Reset state
      repeat (3) cyc();
      check("rst_count", count, 0);
      check("rst_valid", out_valid, 0);
      check("rst_full", full, 0);
      check("rst_cnt_ok", cnt_ok, 0);
      rst = 1'b0;
      repeat (2) cyc();

      // Single accepted frame, head visible one edge later, byte select
      p = rand_pay();
      p[7:0] = 8'hA5;
      p[127:120] = 8'h3C;
      dest_id = 2'd2; src_id = 2'd1; payload = p; frame_valid = 1'b1;
      #1 check("no_bypass", out_valid, 0);
      cyc();
      frame_valid = 1'b0;
      check("lat_valid", out_valid, 1);
      check("lat_src", out_src, 1);
      byte_sel = 4'd0;
      #1 check("byte0", out_byte, 8'hA5);
      byte_sel = 4'd15;
      #1 check("byte15", out_byte, 8'h3C);
      check("ok_one", cnt_ok, 1);
      cyc();
      drain();

      // CRC drop, ID drop, broadcast accept
      clr();
      send(2'd2, 2'd0, 1'b1, rand_pay());
      send(2'd1, 2'd0, 1'b0, rand_pay());
      send(2'd3, 2'd2, 1'b0, rand_pay());
      check("cls_crc", cnt_crc, 1);
      check("cls_id", cnt_id, 1);
      check("cls_ok", cnt_ok, 1);
      check("cls_count", count, 1);
      drain();

      // Overflow: five frames into four slots, then ordered drain
      clr();
      for (int i = 0; i < 5; i++) send(2'd2, 2'(i), 1'b0, rand_pay());
      check("ovf_count", count, 4);
      check("ovf_full", full, 1);
      check("ovf_cnt", cnt_ovf, 1);
      out_ready = 1'b1;
      repeat (4) cyc();
      out_ready = 1'b0;
      check("ovf_drained", out_valid, 0);

      // Push while full with a coincident pop
      clr();
      for (int i = 0; i < 4; i++) send(2'd2, 2'(i), 1'b0, rand_pay());
      p_new = rand_pay();
      dest_id = 2'd2; src_id = 2'd2; payload = p_new;
      frame_valid = 1'b1; out_ready = 1'b1;
      cyc();
      frame_valid = 1'b0; out_ready = 1'b0;
      check("fp_count", count, 4);
      check("fp_ovf", cnt_ovf, 0);
      out_ready = 1'b1;
      repeat (3) cyc();
      out_ready = 1'b0;
      byte_sel = 4'd0;
      #1 check("fp_tail_byte", out_byte, p_new[7:0]);
      check("fp_tail_src", out_src, 2);
      drain();

      // Saturation on the 2-bit instance, then clear with a coincident event
      clr();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(2'd2, 2'(i), 1'b0, rand_pay());
      out_ready = 1'b0;
      check("sat_main", cnt_ok, 5);
      check("sat_small", s_cnt_ok, 3);
      dest_id = 2'd2; src_id = 2'd1; payload = rand_pay();
      frame_valid = 1'b1; clear_stats = 1'b1;
      cyc();
      frame_valid = 1'b0; clear_stats = 1'b0;
      check("clr_small", s_cnt_ok, 0);
      check("clr_main", cnt_ok, 0);
      check("clr_stored", count, 1);
      cyc();
      drain();

      // Held-high level gives one event; reset mid-frame discards everything
      clr();
      dest_id = 2'd2; src_id = 2'd2; payload = rand_pay(); frame_valid = 1'b1;
      repeat (10) cyc();
      frame_valid = 1'b0;
      cyc();
      check("held_ok", cnt_ok, 1);
      send(2'd2, 2'd3, 1'b0, rand_pay());
      check("pre_rst_count", count, 2);
      rst = 1'b1; frame_valid = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      repeat (3) cyc();
      check("post_rst_count", count, 0);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_ok", cnt_ok, 0);
      check("post_rst_crc", cnt_crc, 0);
      frame_valid = 1'b0;
      cyc();
      send(2'd2, 2'd1, 1'b0, rand_pay());
      check("rearm_ok", cnt_ok, 1);
      drain();

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         if (c % 64 == 0) my_id = 2'($urandom_range(0, 3));
         frame_valid = ($urandom_range(0, 99) < 45);
         crc_error   = ($urandom_range(0, 7) == 0);
         dest_id     = 2'($urandom_range(0, 3));
         src_id      = 2'($urandom_range(0, 3));
         payload     = rand_pay();
         out_ready   = ($urandom_range(0, 99) < 40);
         byte_sel    = 4'($urandom_range(0, 15));
         clear_stats = ($urandom_range(0, 59) == 0);
         rst         = (c == 300);
         cyc();
      end
      frame_valid = 1'b0; clear_stats = 1'b0; rst = 1'b0; out_ready = 1'b0;
      repeat (2) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_rx_frame_buffer
`default_nettype wire

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 Parameter ID_W, default 2, node ID width in bits.
REQ-002 Parameter PAYLOAD_BYTES, default 16, payload length in bytes.
REQ-003 Parameter DEPTH, default 4, frame buffer entries; power of two, at least 2.
REQ-004 Parameter CNT_W, default 16, statistics counter width.
REQ-005 Parameter BCAST_EN, default 1, accepts dest_id of all ones as broadcast when 1.
REQ-006 The block SHALL have a single clock and an asynchronous, active-high reset. Ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- my_id  in  ID_W  local node ID.
- frame_valid  in  1  receiver frame-complete level/strobe.
- crc_error  in  1  CRC fail flag, qualified with frame_valid.
- dest_id, src_id  in  ID_W each  header fields, qualified with frame_valid.
- payload  in  PAYLOAD_BYTES*8  frame payload; byte k = payload[8k+7:8k].
- clear_stats  in  1  synchronous clear of all counters.
- out_valid  out  1  head frame available.
- out_ready  in  1  consumer pops head frame.
- out_dest, out_src  out  ID_W each  head frame header.
- byte_sel  in  clog2(PAYLOAD_BYTES)  head payload byte index.
- out_byte  out  8  selected head payload byte.
- count  out  clog2(DEPTH)+1  stored frames.
- full  out  1  count == DEPTH.
- cnt_ok, cnt_crc, cnt_id, cnt_ovf  out  CNT_W each  accepted, CRC-dropped, ID-dropped and overflow-dropped frame counts.

Function
REQ-007 A frame event SHALL be the cycle in which frame_valid is 1 and was 0 in the previous cycle; a held-high frame_valid yields one event.
REQ-008 Each event SHALL be classified with priority CRC, then ID, then overflow:
- crc_error=1: drop, increment cnt_crc.
- Otherwise, if dest_id != my_id and not (BCAST_EN and dest_id all ones): drop, increment cnt_id.
- Otherwise, if full and no pop this cycle: drop, increment cnt_ovf.
- Otherwise: push {dest_id, src_id, payload}, increment cnt_ok.
REQ-009 A pop SHALL occur when out_valid and out_ready are both 1; it removes the head entry.
REQ-010 A push and a pop in the same cycle SHALL both occur. When full, the push SHALL be accepted and count SHALL be unchanged.
REQ-011 Latency: a push into an empty buffer at edge N SHALL make out_valid=1 after edge N, with no bypass path in the same cycle.
REQ-012 out_valid SHALL equal (count != 0). out_dest, out_src and out_byte SHALL reflect the head entry combinationally from byte_sel.
REQ-013 out_dest, out_src and out_byte SHALL be 0 when out_valid is 0.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH.
REQ-015 Head data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 Counters SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-017 clear_stats=1 SHALL zero all counters at the next edge. A frame event in the same cycle SHALL NOT be counted; the push/drop decision is unaffected.
REQ-018 A pop on an empty buffer SHALL be ignored.

Reset
REQ-019 rst=1 SHALL immediately clear the pointers, count, full, out_valid, all counters and the edge-detect register to 0.
REQ-020 Reset in the middle of a frame SHALL discard all stored frames.
REQ-021 A frame_valid held high across reset release SHALL NOT create an event until it falls and rises again.

Structure
REQ-022 A shared package rx_pkg SHALL hold the broadcast-ID function/constant, the frame-entry field layout and the clog2 helper.
REQ-023 Storage SHALL be a sub-module rx_frame_fifo (synchronous, DEPTH x (2*ID_W+PAYLOAD_BYTES*8), push/pop/count/full/empty).
REQ-024 Classification, edge detection and counters SHALL reside in rx_frame_buffer.
REQ-025 The block SHALL contain no latches and no combinational path from frame_valid to out_valid.

Verification
REQ-026 Use defaults with my_id=2. Stimulus: a valid frame with dest=2, src=1, payload byte0=0xA5, byte15=0x3C. Required response: out_valid=1 one edge later; out_src=1; byte_sel=0 gives out_byte=0xA5; byte_sel=15 gives 0x3C; cnt_ok=1.
REQ-027 Stimulus: frames with crc_error=1; with dest=1; and with dest=3 and BCAST_EN=1. Required response: cnt_crc=1, cnt_id=1, cnt_ok=1, count=1.
REQ-028 Stimulus: 5 accepted frames with out_ready=0. Required response: count=4, full=1, cnt_ovf=1. Popping 4 frames returns them in arrival order, and out_valid=0 afterwards.
REQ-029 Stimulus: while full, a new frame arrives in the same cycle as out_ready=1. Required response: cnt_ovf unchanged, count stays 4, and the new frame is the tail.
REQ-030 Stimulus: frame_valid held high 10 cycles, then rst pulsed with 2 frames stored. Required response: exactly one event counted; after reset count=0, out_valid=0 and all counters=0.
REQ-031 Stimulus: CNT_W=2 with 5 accepted frames, then clear_stats coincident with a frame event. Required response: cnt_ok saturates at 3, then reads 0 after the clear while the frame is still stored.
